// File: rtl/axi_pkt_gate.sv
// axi_pkt_gate: store-and-forward packet gate.
// Beats are written into a circular RAM as they arrive. A packet is released
// to the output only after its last beat arrives without error. An errored
// packet is dropped by rewinding the write pointer to the start of the packet.
module axi_pkt_gate #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_terror,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready
);

  localparam int DEPTH = 1 << SIZE;
  localparam logic [SIZE-1:0] PTR_ONE = 1;
  localparam logic [SIZE:0]   CNT_ONE = 1;

  // Each RAM word is {tlast, data}.
  logic [WIDTH:0]  mem_q [DEPTH];

  logic [SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE-1:0] start_addr_q, start_addr_d;
  logic [SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [SIZE:0]   pkt_cnt_q, pkt_cnt_d;

  logic [SIZE-1:0] wr_inc;
  logic [WIDTH:0]  rd_word;
  logic            full, in_hs, out_hs, commit, drop, rd_last;

  // Full leaves one slot empty so that wr == rd always means empty.
  assign wr_inc   = wr_addr_q + PTR_ONE;
  assign full     = (wr_inc == rd_addr_q);
  assign i_tready = ~full;
  assign o_tvalid = (pkt_cnt_q != '0);

  assign rd_word  = mem_q[rd_addr_q];
  assign o_tdata  = rd_word[WIDTH-1:0];
  assign o_tlast  = rd_word[WIDTH];

  assign in_hs    = i_tvalid & i_tready;
  assign out_hs   = o_tvalid & o_tready;
  assign commit   = in_hs & i_tlast & ~i_terror;
  assign drop     = in_hs & i_tlast & i_terror;
  assign rd_last  = out_hs & o_tlast;

  // Storage write; contents are never reset, since pointers define validity.
  always_ff @(posedge clk) begin
    if (in_hs && !clear) mem_q[wr_addr_q] <= {i_tlast, i_tdata};
  end

  // Next-state for pointers and committed-packet count; clear beats any handshake.
  always_comb begin
    wr_addr_d    = wr_addr_q;
    start_addr_d = start_addr_q;
    rd_addr_d    = rd_addr_q;
    pkt_cnt_d    = pkt_cnt_q;
    if (clear) begin
      wr_addr_d    = '0;
      start_addr_d = '0;
      rd_addr_d    = '0;
      pkt_cnt_d    = '0;
    end else begin
      if (drop) begin
        wr_addr_d = start_addr_q;
      end else if (in_hs) begin
        wr_addr_d = wr_inc;
        if (commit) start_addr_d = wr_inc;
      end
      if (out_hs) rd_addr_d = rd_addr_q + PTR_ONE;
      case ({commit, rd_last})
        2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
        2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
        default: pkt_cnt_d = pkt_cnt_q;
      endcase
    end
  end

  // State registers; reset empties the buffer and discards any partial packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr_q    <= '0;
      start_addr_q <= '0;
      rd_addr_q    <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      start_addr_q <= start_addr_d;
      rd_addr_q    <= rd_addr_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_pkt_gate.sv
// Directed bench for axi_pkt_gate (WIDTH=16, SIZE=4 -> 15-beat capacity).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axi_pkt_gate;

  localparam int WIDTH = 16;
  localparam int SIZE  = 4;

  logic             clk = 1'b0;
  logic             reset, clear;
  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast, i_terror, i_tvalid, i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast, o_tvalid, o_tready;

  int vectors = 0;
  int miscompares = 0;

  axi_pkt_gate #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_terror(i_terror),
    .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
    .o_tready(o_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat for one cycle; it must be accepted.
  task automatic push(input logic [WIDTH-1:0] d, input logic l, input logic e);
    chk("push_ready", {31'd0, i_tready}, 32'd1);
    i_tdata = d; i_tlast = l; i_terror = e; i_tvalid = 1'b1;
    @(negedge clk);
    i_tvalid = 1'b0; i_tlast = 1'b0; i_terror = 1'b0;
  endtask

  // Expect a beat on the output (o_tready already high) and let it be taken.
  task automatic pop(input string tag, input logic [WIDTH-1:0] d, input logic l);
    chk({tag, "_vld"},  {31'd0, o_tvalid}, 32'd1);
    chk({tag, "_data"}, {16'd0, o_tdata}, {16'd0, d});
    chk({tag, "_last"}, {31'd0, o_tlast}, {31'd0, l});
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; i_tdata = '0; i_tlast = 1'b0; i_terror = 1'b0;
    i_tvalid = 1'b0; o_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_i_tready", {31'd0, i_tready}, 32'd1);
    chk("rst_o_tvalid", {31'd0, o_tvalid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 3-beat good packet: nothing visible until last beat is in.
    o_tready = 1'b1;
    push(16'h11, 1'b0, 1'b0);
    chk("p1_hold1", {31'd0, o_tvalid}, 32'd0);
    push(16'h22, 1'b0, 1'b0);
    chk("p1_hold2", {31'd0, o_tvalid}, 32'd0);
    push(16'h33, 1'b1, 1'b0);
    pop("p1_b0", 16'h11, 1'b0);
    pop("p1_b1", 16'h22, 1'b0);
    pop("p1_b2", 16'h33, 1'b1);
    chk("p1_done", {31'd0, o_tvalid}, 32'd0);

    // Errored 4-beat packet dropped, then 2-beat good packet; terror on a
    // non-last beat is ignored.
    push(16'h01, 1'b0, 1'b1);
    push(16'h02, 1'b0, 1'b0);
    push(16'h03, 1'b0, 1'b0);
    push(16'h04, 1'b1, 1'b1);
    chk("drop_none", {31'd0, o_tvalid}, 32'd0);
    push(16'h0A, 1'b0, 1'b1);
    push(16'h0B, 1'b1, 1'b0);
    pop("p2_b0", 16'h0A, 1'b0);
    pop("p2_b1", 16'h0B, 1'b1);
    chk("p2_done", {31'd0, o_tvalid}, 32'd0);

    // Three back-to-back 1-beat packets, o_tready toggling.
    i_tdata = 16'h31; i_tlast = 1'b1; i_tvalid = 1'b1; o_tready = 1'b0;
    @(negedge clk);
    chk("tg0_vld",  {31'd0, o_tvalid}, 32'd1);
    chk("tg0_data", {16'd0, o_tdata}, 32'h31);
    chk("tg0_last", {31'd0, o_tlast}, 32'd1);
    i_tdata = 16'h32; o_tready = 1'b1;
    @(negedge clk);
    chk("tg1_vld",  {31'd0, o_tvalid}, 32'd1);
    chk("tg1_data", {16'd0, o_tdata}, 32'h32);
    i_tdata = 16'h33; o_tready = 1'b0;
    @(negedge clk);
    i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b1;
    chk("tg2_data", {16'd0, o_tdata}, 32'h32);
    chk("tg2_last", {31'd0, o_tlast}, 32'd1);
    @(negedge clk);
    o_tready = 1'b0;
    chk("tg3_data", {16'd0, o_tdata}, 32'h33);
    @(negedge clk);
    o_tready = 1'b1;
    chk("tg4_vld",  {31'd0, o_tvalid}, 32'd1);
    chk("tg4_data", {16'd0, o_tdata}, 32'h33);
    chk("tg4_last", {31'd0, o_tlast}, 32'd1);
    @(negedge clk);
    chk("tg_done", {31'd0, o_tvalid}, 32'd0);

    // Commit of B on the same edge as the last-beat read of A.
    o_tready = 1'b0;
    push(16'h41, 1'b0, 1'b0);
    push(16'h42, 1'b1, 1'b0);
    o_tready = 1'b1;
    pop("sa_b0", 16'h41, 1'b0);
    i_tdata = 16'h51; i_tlast = 1'b1; i_tvalid = 1'b1;
    pop("sa_b1", 16'h42, 1'b1);
    i_tvalid = 1'b0; i_tlast = 1'b0;
    pop("sb_b0", 16'h51, 1'b1);
    chk("sb_done", {31'd0, o_tvalid}, 32'd0);

    // Clear with two committed packets and a competing handshake.
    o_tready = 1'b0;
    push(16'h61, 1'b1, 1'b0);
    push(16'h62, 1'b1, 1'b0);
    chk("clr_pre", {31'd0, o_tvalid}, 32'd1);
    clear = 1'b1; i_tdata = 16'h70; i_tlast = 1'b1; i_tvalid = 1'b1;
    @(negedge clk);
    clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
    chk("clr_vld", {31'd0, o_tvalid}, 32'd0);
    chk("clr_rdy", {31'd0, i_tready}, 32'd1);
    o_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("clr_stay", {31'd0, o_tvalid}, 32'd0);

    // Fill to capacity without tlast: ready drops after 15th beat.
    o_tready = 1'b0;
    for (int k = 0; k < 15; k++) push(16'h100 + 16'(k), 1'b0, 1'b0);
    chk("full_rdy", {31'd0, i_tready}, 32'd0);
    chk("full_vld", {31'd0, o_tvalid}, 32'd0);
    i_tdata = 16'h1FF; i_tlast = 1'b1; i_tvalid = 1'b1;
    @(negedge clk);
    chk("full_stall", {31'd0, i_tready}, 32'd0);
    chk("full_nocommit", {31'd0, o_tvalid}, 32'd0);
    i_tvalid = 1'b0; i_tlast = 1'b0;

    // Reset mid-packet discards the partial packet.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_rdy", {31'd0, i_tready}, 32'd1);
    chk("mrst_vld", {31'd0, o_tvalid}, 32'd0);
    o_tready = 1'b1;
    push(16'h77, 1'b1, 1'b0);
    pop("mrst_b0", 16'h77, 1'b1);
    chk("mrst_done", {31'd0, o_tvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
